// File: rtl/udpy_vector_checker.sv
// Exhaustive self-check for the udpY primitive. Each sweep drives all 16 {A,B,C,D}
// vectors, waits a programmable settle time, compares Y against the golden function.
module udpy_vector_checker #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ERR_W         = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             Y,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic             D,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             first_fail_valid,
   output logic [3:0]       first_fail_vec
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYCLES);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   logic [1:0]       state_q, state_d;
   logic [3:0]       vec_q, vec_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             ffv_q, ffv_d;
   logic [3:0]       ffvec_q, ffvec_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             golden;
   logic             mismatch;

   assign golden = (vec_q[3] & ~vec_q[2] & vec_q[0])
                 | (vec_q[2] &  vec_q[1] & ~vec_q[0])
                 | (vec_q[3] &  vec_q[1]);

   // Case inequality so an X or Z on Y is reported as a failure.
   assign mismatch = (Y !== golden);

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffvec_d = ffvec_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SETTLE;
               vec_d   = '0;
               cnt_d   = SETTLE_LD;
               err_d   = '0;
               ffv_d   = 1'b0;
               ffvec_d = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         S_SETTLE: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (mismatch) begin
               if (err_q != ERR_MAX) begin
                  err_d = err_q + ERR_W'(1);
               end
               if (!ffv_q) begin
                  ffv_d   = 1'b1;
                  ffvec_d = vec_q;
               end
            end
            if (vec_q == 4'hF) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               state_d = S_SETTLE;
               vec_d   = vec_q + 4'd1;
               cnt_d   = SETTLE_LD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ffv_q   <= 1'b0;
         ffvec_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffvec_q <= ffvec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign {A, B, C, D}     = vec_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_cnt          = err_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_udpy_vector_checker.sv
// Bench for udpy_vector_checker: three configurations share start/rst, and the Y
// source of each (good udpY, stuck-at, or delayed udpY) is chosen per test.
module tb_udpy_vector_checker;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       pass;
      logic [7:0] err;
      logic       ffv;
      logic [3:0] ffvec;
      logic [3:0] abcd;
   } out_t;

   typedef struct {
      int         which;      // 0: SETTLE=1/ERR_W=5, 1: SETTLE=1/ERR_W=3, 2: SETTLE=0/ERR_W=5
      int         ysel;       // 0 good, 1 tied 0, 2 tied 1, 3 one-stage reg, 4 two-stage reg
      int         exp_cycles;
      int         exp_err;
      logic       exp_pass;
      logic       exp_ffv;
      logic [3:0] exp_ffvec;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   int   ysel = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   function automatic logic udpy(input logic [3:0] v);
      return (v[3] & ~v[2] & v[0]) | (v[2] & v[1] & ~v[0]) | (v[3] & v[1]);
   endfunction

   function automatic logic ysrc(input int sel, input logic comb, input logic r1, input logic r2);
      case (sel)
         0:       return comb;
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return r1;
         default: return r2;
      endcase
   endfunction

   logic       Am, Bm, Cm, Dm, busy_m, done_m, pass_m, ffv_m, ym, y1m, y2m;
   logic [4:0] err_m;
   logic [3:0] ffvec_m;
   logic       As, Bs, Cs, Ds, busy_s, done_s, pass_s, ffv_s, ys, y1s, y2s;
   logic [2:0] err_s;
   logic [3:0] ffvec_s;
   logic       Az, Bz, Cz, Dz, busy_z, done_z, pass_z, ffv_z, yz, y1z, y2z;
   logic [4:0] err_z;
   logic [3:0] ffvec_z;

   always_ff @(posedge clk) begin
      y1m <= udpy({Am, Bm, Cm, Dm});
      y2m <= y1m;
      y1s <= udpy({As, Bs, Cs, Ds});
      y2s <= y1s;
      y1z <= udpy({Az, Bz, Cz, Dz});
      y2z <= y1z;
   end

   always_comb begin
      ym = ysrc(ysel, udpy({Am, Bm, Cm, Dm}), y1m, y2m);
      ys = ysrc(ysel, udpy({As, Bs, Cs, Ds}), y1s, y2s);
      yz = ysrc(ysel, udpy({Az, Bz, Cz, Dz}), y1z, y2z);
   end

   udpy_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(5)) dut_m (
      .clk(clk), .rst(rst), .start(start), .Y(ym),
      .A(Am), .B(Bm), .C(Cm), .D(Dm),
      .busy(busy_m), .done(done_m), .pass(pass_m), .err_cnt(err_m),
      .first_fail_valid(ffv_m), .first_fail_vec(ffvec_m));

   udpy_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(3)) dut_s (
      .clk(clk), .rst(rst), .start(start), .Y(ys),
      .A(As), .B(Bs), .C(Cs), .D(Ds),
      .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s),
      .first_fail_valid(ffv_s), .first_fail_vec(ffvec_s));

   udpy_vector_checker #(.SETTLE_CYCLES(0), .ERR_W(5)) dut_z (
      .clk(clk), .rst(rst), .start(start), .Y(yz),
      .A(Az), .B(Bz), .C(Cz), .D(Dz),
      .busy(busy_z), .done(done_z), .pass(pass_z), .err_cnt(err_z),
      .first_fail_valid(ffv_z), .first_fail_vec(ffvec_z));

   function automatic out_t get_out(input int which);
      out_t o;
      case (which)
         1:       o = '{busy_s, done_s, pass_s, 8'(err_s), ffv_s, ffvec_s, {As, Bs, Cs, Ds}};
         2:       o = '{busy_z, done_z, pass_z, 8'(err_z), ffv_z, ffvec_z, {Az, Bz, Cz, Dz}};
         default: o = '{busy_m, done_m, pass_m, 8'(err_m), ffv_m, ffvec_m, {Am, Bm, Cm, Dm}};
      endcase
      return o;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Cycle count is the index of the edge after which done is first seen,
   // with the edge that samples start numbered 0.
   task automatic wait_done(input int which, inout int cycles);
      while (!get_out(which).done && cycles < 1000) begin
         @(negedge clk);
         cycles++;
      end
      if (cycles >= 1000) chk("done_timeout", cycles, -1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   rec_t tbl[7];

   initial begin
      int   cycles;
      out_t o;

      tbl[0] = '{0, 0, 48,  0, 1'b1, 1'b0, 4'b0000};
      tbl[1] = '{0, 1, 48,  6, 1'b0, 1'b1, 4'b0110};
      tbl[2] = '{1, 2, 48,  7, 1'b0, 1'b1, 4'b0000};
      tbl[3] = '{0, 2, 48, 10, 1'b0, 1'b1, 4'b0000};
      tbl[4] = '{2, 0, 32,  0, 1'b1, 1'b0, 4'b0000};
      // Y is sampled two edges after the vector is driven when SETTLE_CYCLES=0,
      // so only a two-stage delay exceeds the margin; it lags by one vector.
      tbl[5] = '{2, 4, 32,  5, 1'b0, 1'b1, 4'b0110};
      tbl[6] = '{0, 4, 48,  0, 1'b1, 1'b0, 4'b0000};

      do_reset();
      @(negedge clk);
      chk("reset_state", int'(get_out(0)), 0);

      for (int i = 0; i < 7; i++) begin
         ysel = tbl[i].ysel;
         do_reset();
         pulse_start();
         chk($sformatf("t%0d_busy", i), int'(get_out(tbl[i].which).busy), 1);
         cycles = 0;
         wait_done(tbl[i].which, cycles);
         o = get_out(tbl[i].which);
         chk($sformatf("t%0d_cycles", i), cycles, tbl[i].exp_cycles);
         chk($sformatf("t%0d_err", i), int'(o.err), tbl[i].exp_err);
         chk($sformatf("t%0d_pass", i), int'(o.pass), int'(tbl[i].exp_pass));
         chk($sformatf("t%0d_ffv", i), int'(o.ffv), int'(tbl[i].exp_ffv));
         chk($sformatf("t%0d_ffvec", i), int'(o.ffvec), int'(tbl[i].exp_ffvec));
         chk($sformatf("t%0d_abcd", i), int'(o.abcd), 15);
         chk($sformatf("t%0d_busy_end", i), int'(o.busy), 0);
      end

      // Reset in the middle of a sweep, then a clean sweep.
      ysel = 1;
      do_reset();
      pulse_start();
      cycles = 0;
      while (get_out(0).abcd != 4'd7 && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      chk("mid_reach_vec7", int'(get_out(0).abcd), 7);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_reset_state", int'(get_out(0)), 0);
      rst  = 1'b0;
      ysel = 0;
      pulse_start();
      cycles = 0;
      wait_done(0, cycles);
      chk("post_reset_cycles", cycles, 48);
      chk("post_reset_pass", int'(get_out(0).pass), 1);

      // start at vector 3 while busy is ignored.
      do_reset();
      pulse_start();
      cycles = 0;
      while (get_out(0).abcd != 4'd3 && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      chk("busy_reach_vec3", int'(get_out(0).abcd), 3);
      start = 1'b1;
      @(negedge clk);
      cycles++;
      start = 1'b0;
      chk("busy_start_no_restart", int'(get_out(0).abcd), 3);
      wait_done(0, cycles);
      chk("busy_start_cycles", cycles, 48);
      chk("busy_start_err", int'(get_out(0).err), 0);

      // start in DONE after a failing sweep clears the results on the next edge.
      ysel = 1;
      do_reset();
      pulse_start();
      cycles = 0;
      wait_done(0, cycles);
      chk("done_prev_err", int'(get_out(0).err), 6);
      ysel = 0;
      pulse_start();
      o = get_out(0);
      chk("restart_done", int'(o.done), 0);
      chk("restart_busy", int'(o.busy), 1);
      chk("restart_err", int'(o.err), 0);
      chk("restart_ffv", int'(o.ffv), 0);
      chk("restart_abcd", int'(o.abcd), 0);
      cycles = 0;
      wait_done(0, cycles);
      chk("restart_cycles", cycles, 48);
      chk("restart_pass", int'(get_out(0).pass), 1);

      // rst and start together: reset takes priority.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_start_same", int'(get_out(0)), 0);
      @(negedge clk);
      chk("rst_start_idle", int'(get_out(0).busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
